// File: rtl/avalon_pio_irq_ctrl.sv
// Avalon-MM input PIO: per-channel synchroniser, optional glitch filter, edge/level
// event detection into a write-1-to-clear capture register, and one masked interrupt.
module avalon_pio_irq_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int SETTLE = SYNC_STAGES + FILTER_CYCLES + 1;
  localparam int STW    = $clog2(SETTLE + 1);
  localparam logic [STW-1:0] SETTLE_V = STW'(SETTLE);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RISE  = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_CAP   = 3'd3;
  localparam logic [2:0] ADDR_FALL  = 3'd4;
  localparam logic [2:0] ADDR_LEVEL = 3'd5;

  logic [SYNC_STAGES*WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_prev_q;
  logic [WIDTH-1:0] rise_en_q, fall_en_q, mask_q, level_q;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise, fall, event_w, clr;
  logic [STW-1:0]   settle_q;
  logic             settled;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  assign sync_s       = sync_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign filt = sync_s;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] CLAST = CW'(FILTER_CYCLES - 1);
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic          filt_q, filt_d;

        // The count that would reach FILTER_CYCLES instead commits the new value.
        always_comb begin
          cnt_d  = '0;
          filt_d = filt_q;
          if (sync_s[gi] != filt_q) begin
            if (cnt_q == CLAST) filt_d = sync_s[gi];
            else                cnt_d  = cnt_q + CW'(1);
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
          end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
          end
        end

        assign filt[gi] = filt_q;
      end
    end
  endgenerate

  // Edge events are held off until the chains have refilled after reset, so an
  // input that was already high does not look like a fresh rising edge.
  assign settled = (settle_q == SETTLE_V);
  assign rise    = filt & ~filt_prev_q;
  assign fall    = ~filt & filt_prev_q;
  assign event_w = (level_q & filt)
                 | (~level_q & {WIDTH{settled}} & ((rise & rise_en_q) | (fall & fall_en_q)));
  assign clr     = (wr_en && address == ADDR_CAP) ? writedata[WIDTH-1:0] : '0;
  assign cap_d   = event_w | (cap_q & ~clr);

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:  readdata_d[WIDTH-1:0] = filt;
      ADDR_RISE:  readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_MASK:  readdata_d[WIDTH-1:0] = mask_q;
      ADDR_CAP:   readdata_d[WIDTH-1:0] = cap_q;
      ADDR_FALL:  readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_LEVEL: readdata_d[WIDTH-1:0] = level_q;
      default:    readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      filt_prev_q <= '0;
      settle_q    <= '0;
      cap_q       <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      mask_q      <= '0;
      level_q     <= '0;
      readdata_q  <= '0;
    end else begin
      sync_q      <= {sync_q[(SYNC_STAGES-1)*WIDTH-1:0], in_port};
      filt_prev_q <= filt;
      if (!settled) settle_q <= settle_q + STW'(1);
      cap_q       <= cap_d;
      readdata_q  <= readdata_d;
      if (wr_en) begin
        case (address)
          ADDR_RISE:  rise_en_q <= writedata[WIDTH-1:0];
          ADDR_MASK:  mask_q    <= writedata[WIDTH-1:0];
          ADDR_FALL:  fall_en_q <= writedata[WIDTH-1:0];
          ADDR_LEVEL: level_q   <= writedata[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule
